// File: rtl/event_encoder4_to2.sv
//==============================================================================
// Module  : event_encoder4_to2
// Brief   : Latches rising edges on four request lines and issues them one at
//           a time as a 2-bit code on a valid/ready port, round-robin fair.
// Revision: 1.0
//==============================================================================
`default_nettype none

module event_encoder4_to2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [3:0] d,
  input  logic       ready,
  output logic [1:0] q,
  output logic       valid,
  output logic [3:0] pend,
  output logic       lost
);

  localparam logic [3:0] c_one_hot_base = 4'b0001;

  logic [3:0] d_prev_q, d_prev_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] q_q, q_d;
  logic       valid_q, valid_d;
  logic       lost_q, lost_d;

  logic [3:0] w_rise;
  logic [3:0] w_clr;
  logic       w_load;
  logic       w_found;
  logic       w_issue;
  logic [1:0] w_sel;
  logic [1:0] w_idx;

  // Round-robin search starts at ptr and wraps 3->0; the first hit wins.
  always_comb begin
    w_sel   = 2'b00;
    w_found = 1'b0;
    w_idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      w_idx = ptr_q + 2'(k);
      if (!w_found && pend_q[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_rise   = d & ~d_prev_q & {4{En}};
    w_load   = ~valid_q | ready;
    w_issue  = w_load & w_found;
    w_clr    = w_issue ? (c_one_hot_base << w_sel) : 4'b0000;

    d_prev_d = d;
    // A rise on the line being issued this cycle re-arms it: set beats clear.
    pend_d   = (pend_q & ~w_clr) | w_rise;
    lost_d   = |(w_rise & pend_q & ~w_clr);

    q_d      = q_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    if (w_load) begin
      valid_d = w_found;
      if (w_found) begin
        q_d   = w_sel;
        ptr_d = w_sel + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_prev_q <= 4'b0000;
      pend_q   <= 4'b0000;
      ptr_q    <= 2'b00;
      q_q      <= 2'b00;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      d_prev_q <= d_prev_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign lost  = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_event_encoder4_to2.sv
//==============================================================================
// Module  : tb_event_encoder4_to2
// Brief   : Directed stimulus with a queue of expected issue codes; a monitor
//           compares each completed transfer against the queue.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_event_encoder4_to2;

  logic       clk;
  logic       rst;
  logic       En;
  logic [3:0] d;
  logic       ready;
  logic [1:0] q;
  logic       valid;
  logic [3:0] pend;
  logic       lost;

  int         vectors;
  int         miscompares;
  logic [1:0] exp_q[$];

  event_encoder4_to2 dut (
    .clk   (clk),
    .rst   (rst),
    .En    (En),
    .d     (d),
    .ready (ready),
    .q     (q),
    .valid (valid),
    .pend  (pend),
    .lost  (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    En    = 1'b1;
    d     = 4'b1111;
    ready = 1'b1;

    // Monitor: a transfer happens at the next edge whenever valid & ready.
    fork
      forever begin
        @(negedge clk);
        if (!rst && valid && ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_transfer", {2'b00, q}, 4'b1111);
          end else begin
            chk("issued_code", {2'b00, q}, {2'b00, exp_q.pop_front()});
          end
        end
      end
    join_none

    // Reset with all lines high
    step(); step();
    chk("rst_q", {2'b00, q}, 4'b0000);
    chk("rst_valid", {3'b000, valid}, 4'b0000);
    chk("rst_pend", pend, 4'b0000);
    chk("rst_lost", {3'b000, lost}, 4'b0000);

    // Release: lines already high count as rises; drain 0,1,2,3 from ptr=0
    rst = 1'b0;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    step();
    chk("rel_pend", pend, 4'b1111);
    chk("rel_valid", {3'b000, valid}, 4'b0000);
    repeat (5) step();
    chk("rr0_valid_end", {3'b000, valid}, 4'b0000);
    chk("rr0_pend_end", pend, 4'b0000);

    // Single event on line 2
    d = 4'b0000; step();
    d = 4'b0100; exp_q.push_back(2'd2);
    step();
    chk("single_pend", pend, 4'b0100);
    chk("single_valid0", {3'b000, valid}, 4'b0000);
    step();
    chk("single_valid1", {3'b000, valid}, 4'b0001);
    chk("single_q", {2'b00, q}, 4'b0010);
    step();
    chk("single_valid_end", {3'b000, valid}, 4'b0000);

    // Round robin starting from ptr=3: 3,0,1,2
    d = 4'b0000; step();
    d = 4'b1111;
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    step();
    chk("rr3_pend", pend, 4'b1111);
    repeat (5) step();
    chk("rr3_valid_end", {3'b000, valid}, 4'b0000);

    // Backpressure: pend=0110 from ptr=3 issues line 1 and holds it
    d = 4'b0000; ready = 1'b0; step();
    d = 4'b0110; exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    step();
    chk("bp_pend", pend, 4'b0110);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {3'b000, valid}, 4'b0001);
      chk("bp_hold_q", {2'b00, q}, 4'b0001);
      chk("bp_hold_pend", pend, 4'b0100);
      step();
    end
    ready = 1'b1;
    step();
    chk("bp_next_q", {2'b00, q}, 4'b0010);
    chk("bp_next_pend", pend, 4'b0000);
    step();
    chk("bp_valid_end", {3'b000, valid}, 4'b0000);

    // Drop: line 2 pending behind a stalled line 0
    ready = 1'b0; d = 4'b0000; step();
    d = 4'b0101; exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    step();
    chk("drop_pend0", pend, 4'b0101);
    step();
    chk("drop_q", {2'b00, q}, 4'b0000);
    chk("drop_pend1", pend, 4'b0100);
    d = 4'b0001; step();
    d = 4'b0101; step();
    chk("drop_lost", {3'b000, lost}, 4'b0001);
    chk("drop_pend2", pend, 4'b0100);
    d = 4'b0001; step();
    chk("drop_lost_clear", {3'b000, lost}, 4'b0000);

    // Set wins: line 2 rises on the edge that issues line 2
    ready = 1'b1; d = 4'b0101;
    step();
    chk("sw_q", {2'b00, q}, 4'b0010);
    chk("sw_pend", pend, 4'b0100);
    chk("sw_lost", {3'b000, lost}, 4'b0000);
    step();
    chk("sw_reissue_q", {2'b00, q}, 4'b0010);
    chk("sw_reissue_pend", pend, 4'b0000);
    step();
    chk("sw_valid_end", {3'b000, valid}, 4'b0000);

    // En gating
    En = 1'b0; d = 4'b0000; step();
    d = 4'b1111; step(); step();
    chk("en_pend", pend, 4'b0000);
    chk("en_valid", {3'b000, valid}, 4'b0000);
    chk("en_lost", {3'b000, lost}, 4'b0000);

    // Mid-drain asynchronous reset (ptr=3 so line 3 issues first)
    En = 1'b1; d = 4'b0000; step();
    d = 4'b1010; step();
    chk("mr_pend", pend, 4'b1010);
    ready = 1'b0;
    step();
    chk("mr_q", {2'b00, q}, 4'b0011);
    chk("mr_valid", {3'b000, valid}, 4'b0001);
    #2 rst = 1'b1; d = 4'b0000;
    #1;
    chk("mr_rst_pend", pend, 4'b0000);
    chk("mr_rst_valid", {3'b000, valid}, 4'b0000);
    chk("mr_rst_q", {2'b00, q}, 4'b0000);
    step();
    rst = 1'b0; ready = 1'b1;
    step();
    chk("mr_after_valid", {3'b000, valid}, 4'b0000);
    chk("mr_after_pend", pend, 4'b0000);

    chk("queue_drained", 4'(exp_q.size()), 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, limit 50000 reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
